// File: rtl/sha256_two_block_pipe_pkg.sv
// SHA-256 constants, word/state types and round helper functions
// shared by the round stages and the two-block pipeline top.
package sha256_two_block_pipe_pkg;

    typedef logic [31:0] word_t;
    // Index 0 holds a / H0 so the packed layout matches the digest port.
    typedef word_t [7:0]  state_t;
    // Index 0 is the word consumed by the current round.
    typedef word_t [15:0] sched_t;

    localparam int ROUNDS = 64;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Concatenation lists H7 first because index 0 is the LSB word.
    localparam state_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic state_t add_state(input state_t x, input state_t y);
        state_t s;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] + y[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/sha256_round_stage.sv
// One registered SHA-256 round plus schedule-window shift; 1-cycle latency,
// never stalls. The chaining value rides along for the final feed-forward add.
module sha256_round_stage
    import sha256_two_block_pipe_pkg::*;
#(
    parameter int ROUND = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   vld_i,
    input  state_t st_i,
    input  sched_t w_i,
    input  state_t cv_i,
    output logic   vld_o,
    output state_t st_o,
    output sched_t w_o,
    output state_t cv_o
);

    logic   vld_q;
    state_t st_q, st_d;
    sched_t w_q, w_d;
    state_t cv_q;
    word_t  t1, t2;

    always_comb begin
        t1 = st_i[7] + bsig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + K[ROUND] + w_i[0];
        t2 = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

        st_d    = st_i;
        st_d[7] = st_i[6];
        st_d[6] = st_i[5];
        st_d[5] = st_i[4];
        st_d[4] = st_i[3] + t1;
        st_d[3] = st_i[2];
        st_d[2] = st_i[1];
        st_d[1] = st_i[0];
        st_d[0] = t1 + t2;

        // Window slides by one; the new tail word is W[ROUND+16].
        w_d        = w_i;
        w_d[14:0]  = w_i[15:1];
        w_d[15]    = ssig1(w_i[14]) + w_i[9] + ssig0(w_i[1]) + w_i[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        st_q <= st_d;
        w_q  <= w_d;
        cv_q <= cv_i;
    end

    assign vld_o = vld_q;
    assign st_o  = st_q;
    assign w_o   = w_q;
    assign cv_o  = cv_q;

endmodule

// File: rtl/sha256_two_block_pipe.sv
// Fully pipelined two-block SHA-256: block A on phase-0 edges, block B on the next edge,
// digest registered 129 edges after block A; free-running, no backpressure.
module sha256_two_block_pipe
    import sha256_two_block_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] msg_in,
    output logic [255:0] final_out
);

    logic   phase_q, phase_d;
    logic   [ROUNDS:0] s1_vld, s2_vld;
    state_t s1_st [0:ROUNDS];
    sched_t s1_w  [0:ROUNDS];
    state_t s1_cv [0:ROUNDS];
    state_t s2_st [0:ROUNDS];
    sched_t s2_w  [0:ROUNDS];
    state_t s2_cv [0:ROUNDS];
    sched_t blk_b [0:ROUNDS-1];
    logic   cv_vld_q;
    state_t cv_q;
    state_t final_q, final_d;
    logic   unused_sched;

    assign phase_d = ~phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            cv_vld_q <= 1'b0;
            final_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            cv_vld_q <= s1_vld[ROUNDS];
            final_q  <= final_d;
        end
    end

    assign s1_vld[0] = ~phase_q;
    assign s1_st[0]  = IV;
    assign s1_w[0]   = msg_in;
    assign s1_cv[0]  = IV;

    genvar t;
    for (t = 0; t < ROUNDS; t++) begin : g_set1
        sha256_round_stage #(.ROUND(t)) u_rnd (
            .clk   (clk),
            .rst   (rst),
            .vld_i (s1_vld[t]),
            .st_i  (s1_st[t]),
            .w_i   (s1_w[t]),
            .cv_i  (s1_cv[t]),
            .vld_o (s1_vld[t+1]),
            .st_o  (s1_st[t+1]),
            .w_o   (s1_w[t+1]),
            .cv_o  (s1_cv[t+1])
        );
    end

    // Registering CV costs one edge, which the block-B line absorbs.
    always_ff @(posedge clk) begin
        cv_q <= add_state(s1_cv[ROUNDS], s1_st[ROUNDS]);
    end

    // Capture register plus 63 delay registers: B leaves in step with CV.
    for (t = 0; t < ROUNDS; t++) begin : g_bdly
        sched_t dly_q;
        if (t == 0) begin : g_cap
            always_ff @(posedge clk) dly_q <= msg_in;
        end else begin : g_shift
            always_ff @(posedge clk) dly_q <= blk_b[t-1];
        end
        assign blk_b[t] = dly_q;
    end

    assign s2_vld[0] = cv_vld_q;
    assign s2_st[0]  = cv_q;
    assign s2_w[0]   = blk_b[ROUNDS-1];
    assign s2_cv[0]  = cv_q;

    for (t = 0; t < ROUNDS; t++) begin : g_set2
        sha256_round_stage #(.ROUND(t)) u_rnd (
            .clk   (clk),
            .rst   (rst),
            .vld_i (s2_vld[t]),
            .st_i  (s2_st[t]),
            .w_i   (s2_w[t]),
            .cv_i  (s2_cv[t]),
            .vld_o (s2_vld[t+1]),
            .st_o  (s2_st[t+1]),
            .w_o   (s2_w[t+1]),
            .cv_o  (s2_cv[t+1])
        );
    end

    always_comb begin
        final_d = final_q;
        if (s2_vld[ROUNDS]) begin
            final_d = add_state(s2_cv[ROUNDS], s2_st[ROUNDS]);
        end
    end

    assign final_out    = final_q;
    assign unused_sched = ^{s1_w[ROUNDS], s2_w[ROUNDS]};

endmodule

// File: tb/tb_sha256_two_block_pipe.sv
// Bench for sha256_two_block_pipe: table vectors, random back-to-back pairs and
// a mid-flight reset, scored against a plain software SHA-256 model.
module tb_sha256_two_block_pipe;

    typedef logic [31:0]       word_t;
    typedef logic [7:0][31:0]  dig_t;
    typedef logic [15:0][31:0] blk_t;

    typedef struct {
        blk_t  a;
        blk_t  b;
        dig_t  exp;
        string nm;
    } vec_t;

    typedef struct {
        int    launch;
        dig_t  exp;
        string nm;
    } sb_t;

    logic clk;
    logic rst;
    blk_t msg_in;
    dig_t final_out;

    sha256_two_block_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .msg_in    (msg_in),
        .final_out (final_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t km [64];
    dig_t  ivm;
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    dig_t  prev   = '0;
    vec_t  pend [$];
    sb_t   sb   [$];
    vec_t  drv_v;
    sb_t   drv_s;
    blk_t  cur_b;
    vec_t  tbl  [3];

    function automatic word_t rr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic dig_t compress(input dig_t h, input blk_t m);
        word_t w [64];
        word_t v [8];
        word_t t1, t2;
        dig_t  r;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = h[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + km[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
        return r;
    endfunction

    function automatic dig_t model(input blk_t a, input blk_t b);
        return compress(compress(ivm, a), b);
    endfunction

    function automatic blk_t rand_blk();
        blk_t r;
        for (int i = 0; i < 16; i++) r[i] = $urandom;
        return r;
    endfunction

    // Round constants and IV derived from prime roots, independent of the RTL tables.
    task automatic init_consts();
        int  primes [64];
        int  n = 2;
        int  cnt = 0;
        bit  isp;
        real r;
        while (cnt < 64) begin
            isp = 1'b1;
            for (int d = 2; d * d <= n; d++) if (n % d == 0) isp = 1'b0;
            if (isp) begin
                primes[cnt] = n;
                cnt++;
            end
            n++;
        end
        for (int i = 0; i < 64; i++) begin
            r = $pow(real'(primes[i]), 1.0 / 3.0);
            r = r - (r * r * r - real'(primes[i])) / (3.0 * r * r);
            km[i] = word_t'(longint'($floor((r - $floor(r)) * 4294967296.0)));
        end
        for (int i = 0; i < 8; i++) begin
            r = $sqrt(real'(primes[i]));
            ivm[i] = word_t'(longint'($floor((r - $floor(r)) * 4294967296.0)));
        end
    endtask

    task automatic chk(input bit ok, input string nm, input dig_t act, input dig_t exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s @edge %0d: got %h want %h", nm, cyc, act, exp);
    endtask

    // Drives A on odd edges after reset release and B on the following edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (((cyc + 1) % 2) == 1) begin
                if (pend.size() > 0) begin
                    drv_v = pend.pop_front();
                end else begin
                    drv_v.a   = rand_blk();
                    drv_v.b   = rand_blk();
                    drv_v.exp = model(drv_v.a, drv_v.b);
                    drv_v.nm  = "rand_fill";
                end
                msg_in       = drv_v.a;
                cur_b        = drv_v.b;
                drv_s.launch = cyc + 1;
                drv_s.exp    = drv_v.exp;
                drv_s.nm     = drv_v.nm;
                sb.push_back(drv_s);
            end else begin
                msg_in = cur_b;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk(final_out === '0, "reset_zero", final_out, '0);
            sb.delete();
            cyc  = 0;
            prev = '0;
        end else begin
            cyc++;
            if (sb.size() > 0 && sb[0].launch + 129 == cyc) begin
                chk(final_out === sb[0].exp, sb[0].nm, final_out, sb[0].exp);
                prev = final_out;
                void'(sb.pop_front());
            end else begin
                chk(final_out === prev, "hold", final_out, prev);
            end
        end
    end

    initial begin
        blk_t       abc_a, abc_b, pad_b, data;
        logic [7:0] c;
        vec_t       v;

        rst    = 1'b1;
        msg_in = '0;
        cur_b  = '0;
        init_consts();

        abc_a = '0;
        for (int i = 0; i < 14; i++) begin
            c = 8'h61 + 8'(i);
            abc_a[i] = {c, c + 8'd1, c + 8'd2, c + 8'd3};
        end
        abc_a[14] = 32'h80000000;
        abc_b     = '0;
        abc_b[15] = 32'h000001c0;
        pad_b     = '0;
        pad_b[0]  = 32'h80000000;
        pad_b[15] = 32'h00000200;

        tbl[0].a   = abc_a;
        tbl[0].b   = abc_b;
        tbl[0].exp = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                      32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
        tbl[0].nm  = "abc_two_block";
        data       = rand_blk();
        tbl[1].a   = data;
        tbl[1].b   = pad_b;
        tbl[1].exp = model(data, pad_b);
        tbl[1].nm  = "rand64_padded";
        data       = '1;
        tbl[2].a   = data;
        tbl[2].b   = pad_b;
        tbl[2].exp = model(data, pad_b);
        tbl[2].nm  = "ones64_padded";

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 3; i++) pend.push_back(tbl[i]);
        for (int k = 0; k < 3; k++) begin
            v.a   = rand_blk();
            v.b   = rand_blk();
            v.exp = model(v.a, v.b);
            v.nm  = $sformatf("rand_seq%0d", k);
            pend.push_back(v);
        end
        repeat (300) @(posedge clk);

        v.a   = rand_blk();
        v.b   = rand_blk();
        v.exp = model(v.a, v.b);
        v.nm  = "killed_pair";
        pend.push_back(v);
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        pend.push_back(tbl[0]);
        repeat (200) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
